// File: rtl/pkt_serial_tx.sv
// rtl/pkt_serial_tx.sv - FIFO-fed asynchronous serial frame transmitter (optional parity via PKT_SERIAL_TX_PARITY_EN)
module pkt_serial_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  fifo_pkt,
    input  logic        fifo_empty,
    output logic        fifo_re,
    input  logic        hold,
    output logic        txd,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef PKT_SERIAL_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0] state;
    logic [9:0] shift;
    logic [7:0] baud;
    logic [3:0] bit_cnt;
    logic       baud_last;
`ifdef PKT_SERIAL_TX_PARITY_EN
    logic       parity;
`endif

    assign baud_last = (baud == 8'(CLKS_PER_BIT - 1));
    assign fifo_re   = (state == S_IDLE) & ~fifo_empty & ~hold & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            shift     <= '0;
            baud      <= '0;
            bit_cnt   <= '0;
            txd       <= 1'b1;
            busy      <= 1'b0;
            frame_cnt <= '0;
`ifdef PKT_SERIAL_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (fifo_re) begin
                        shift   <= fifo_pkt;
                        baud    <= '0;
                        bit_cnt <= '0;
                        txd     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_START;
`ifdef PKT_SERIAL_TX_PARITY_EN
                        parity  <= ^fifo_pkt;
`endif
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud  <= '0;
                        txd   <= shift[0];
                        state <= S_DATA;
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud    <= '0;
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd9) begin
`ifdef PKT_SERIAL_TX_PARITY_EN
                            txd   <= parity;
                            state <= S_PARITY;
`else
                            txd   <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            // txd takes the next bit now; shift catches up on this same edge
                            txd <= shift[1];
                        end
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
`ifdef PKT_SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_last) begin
                        baud  <= '0;
                        txd   <= 1'b1;
                        state <= S_STOP;
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_last) begin
                        baud      <= '0;
                        busy      <= 1'b0;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= S_IDLE;
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                    baud  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_serial_tx.sv
// tb/tb_pkt_serial_tx.sv - randomized self-checking bench for pkt_serial_tx against a frame-level model
module tb_pkt_serial_tx;

`ifdef PKT_SERIAL_TX_PARITY_EN
    localparam int C   = 2;
    localparam int PAR = 1;
`else
    localparam int C   = 4;
    localparam int PAR = 0;
`endif
    localparam int PERIOD = (12 + PAR) * C + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  fifo_pkt;
    logic        fifo_empty;
    logic        fifo_re;
    logic        hold = 1'b0;
    logic        txd;
    logic        busy;
    logic [15:0] frame_cnt;

    logic [9:0]  mem [0:255];
    logic [7:0]  rd = '0;
    logic [7:0]  wr = '0;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          exp_bits[$];
    int          pop_cycles[$];
    logic [15:0] exp_cnt = '0;
    bit          exp_re;

    pkt_serial_tx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_pkt   (fifo_pkt),
        .fifo_empty (fifo_empty),
        .fifo_re    (fifo_re),
        .hold       (hold),
        .txd        (txd),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd == wr);
    assign fifo_pkt   = fifo_empty ? 10'h000 : mem[rd];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_re) rd <= rd + 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [9:0] pkt);
        mem[wr] = pkt;
        wr = wr + 8'd1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(fifo_empty && exp_bits.size() == 0) && n < bound);
        check("wait_idle_timeout", 32'(n < bound), 32'd1);
    endtask

    // Reference: a frame is a list of line levels, each held C cycles; IDLE is "no bits pending".
    always @(negedge clk) begin
        if (rst) begin
            exp_bits.delete();
            exp_cnt = '0;
        end else begin
            exp_re = (exp_bits.size() == 0) && !fifo_empty && !hold;
            check("fifo_re", 32'(fifo_re), 32'(exp_re));
            check("txd", 32'(txd), 32'(exp_bits.size() != 0 ? exp_bits[0] : 1'b1));
            check("busy", 32'(busy), 32'(exp_bits.size() != 0));
            check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
            if (exp_bits.size() != 0) begin
                void'(exp_bits.pop_front());
                if (exp_bits.size() == 0) exp_cnt = exp_cnt + 16'd1;
            end
            if (exp_re) begin
                pop_cycles.push_back(cyc);
                for (int k = 0; k < C; k++) exp_bits.push_back(1'b0);
                for (int b = 0; b < 10; b++)
                    for (int k = 0; k < C; k++) exp_bits.push_back(fifo_pkt[b]);
                if (PAR != 0)
                    for (int k = 0; k < C; k++) exp_bits.push_back(^fifo_pkt);
                for (int k = 0; k < C; k++) exp_bits.push_back(1'b1);
            end
        end
    end

    initial begin
        int s;
        repeat (3) step();
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fifo_re", 32'(fifo_re), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        step();

        push(10'h2A5);
        wait_idle(200);
        check("single_frame_cnt", 32'(frame_cnt), 32'd1);

        push(10'h001);
        push(10'h3FF);
        push(10'h000);
        wait_idle(400);
        s = pop_cycles.size();
        check("pop_gap_1", 32'(pop_cycles[s-2] - pop_cycles[s-3]), 32'(PERIOD));
        check("pop_gap_2", 32'(pop_cycles[s-1] - pop_cycles[s-2]), 32'(PERIOD));
        check("three_frame_cnt", 32'(frame_cnt), 32'd4);
        repeat (20) step();

        hold = 1'b1;
        push(10'h155);
        repeat (100) step();
        check("hold_pkt_kept", 32'(fifo_empty), 32'd0);
        hold = 1'b0;
        repeat (3 * C + 2) step();
        push(10'h0F0);
        hold = 1'b1;
        repeat (15 * C + 30) step();
        check("hold_frame_done", 32'(busy), 32'd0);
        check("hold_no_pop", 32'(fifo_empty), 32'd0);
        check("hold_cnt", 32'(frame_cnt), 32'd5);
        hold = 1'b0;
        wait_idle(200);

        push(10'h3C3);
        push(10'h2B4);
        repeat (6 * C + 2) step();
        #2 rst = 1'b1;
        #1;
        check("async_rst_txd", 32'(txd), 32'd1);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_cnt", 32'(frame_cnt), 32'd0);
        step();
        rst = 1'b0;
        wait_idle(200);
        check("post_rst_cnt", 32'(frame_cnt), 32'd1);

        for (int i = 0; i < 10; i++) begin
            push(10'($urandom_range(0, 1023)));
            if ($urandom_range(0, 2) == 0) push(10'($urandom_range(0, 1023)));
            repeat ($urandom_range(0, 3 * C)) step();
            if ($urandom_range(0, 1) == 1) begin
                hold = 1'b1;
                repeat ($urandom_range(1, 20 * C)) step();
                hold = 1'b0;
            end
            wait_idle(600);
        end

        step();
        force dut.frame_cnt = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        push(10'h37A);
        wait_idle(200);
        check("cnt_wrap", 32'(frame_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
